// File: rtl/aes_core_arbiter_pkg.sv
// Shared types and constants for the AES core arbiter (package aes_arb_pkg).
// Optional feature macro: AES_ARB_TIMEOUT_EN (WAIT-state timeout with rsp_error).
package aes_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_W_DEF     = 128;
  localparam int TIMEOUT_CYCLES = 63;
  localparam int TMO_W          = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_e;

  // Width of a requester index; never below one bit so single-requester builds elaborate.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Bus bundle between the requesters/AES core (master side) and the arbiter (slave side).
// Optional feature macro seen through this bus: AES_ARB_TIMEOUT_EN drives rsp_error.
//
// Handshake semantics:
//   request  : a requester raises req_valid[i] with req_data slice i and holds both
//              until it sees req_ready[i]; a transfer happens on a cycle where both
//              are high. req_ready is a single-cycle one-hot pulse.
//   core     : core_start is a one-cycle pulse qualifying core_plain; the core answers
//              with a one-cycle core_done pulse, core_cipher valid only on that cycle.
//   response : rsp_valid (one-hot) with rsp_data/rsp_error stays high and stable until
//              rsp_ready is seen high; that cycle completes the transfer.
interface aes_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      core_start;
  logic [DATA_W-1:0]         core_plain;
  logic                      core_done;
  logic [DATA_W-1:0]         core_cipher;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ready;
  logic                      rsp_error;

  modport master (
    output req_valid, req_data, core_done, core_cipher, rsp_ready,
    input  req_ready, core_start, core_plain, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_data, core_done, core_cipher, rsp_ready,
    output req_ready, core_start, core_plain, rsp_valid, rsp_data, rsp_error
  );

endinterface

// File: rtl/aes_core_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_req
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requests starting at rr_ptr; the first hit becomes the one-hot grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between NUM_REQ requesters, one job at a time.
// Optional feature macro: AES_ARB_TIMEOUT_EN adds a 6-bit WAIT timeout that answers
// with rsp_error=1 and zero data when the core never signals done.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  aes_core_arbiter_if.slave bus,
  output logic              busy,
  output arb_state_e        dbg_state
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  arb_state_e         state;
  arb_state_e         state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] pick_oh;
  logic               any_req;
  logic [PTR_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;
  logic [DATA_W-1:0]  core_plain_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [NUM_REQ-1:0] rsp_valid_c;
  logic               timeout_hit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (pick_oh),
    .any_req (any_req)
  );

  // Turn the one-hot pick into an index and select that requester's plaintext.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        win_idx  = PTR_W'(i);
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp_error_q;

  // Count WAIT cycles; cleared in LAUNCH so each job starts its budget at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // The 63rd WAIT cycle without core_done gives up; a same-cycle core_done wins.
  assign timeout_hit = (state == WAIT) && (tmo_cnt == TMO_LAST) && !bus.core_done;

  // Error flag: raised by a timeout, dropped by a normal completion or the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_error_q <= 1'b0;
    end else if (state == WAIT && bus.core_done) begin
      rsp_error_q <= 1'b0;
    end else if (timeout_hit) begin
      rsp_error_q <= 1'b1;
    end else if (state == RESPOND && bus.rsp_ready) begin
      rsp_error_q <= 1'b0;
    end
  end

  assign bus.rsp_error = rsp_error_q;
`else
  assign timeout_hit   = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: one job in flight; core_done only matters in WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (bus.core_done || timeout_hit) state_next = RESPOND;
      RESPOND: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job datapath: latch the winner at accept, the ciphertext at done, advance rr_ptr at handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      grant        <= '0;
      core_plain_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant        <= win_idx;
            core_plain_q <= win_data;
          end
        end
        WAIT: begin
          if (bus.core_done) begin
            rsp_data_q <= bus.core_cipher;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
          end
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            rr_ptr <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // One-hot response valid toward the requester that owns the job.
  always_comb begin
    rsp_valid_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state == RESPOND && grant == PTR_W'(i)) begin
        rsp_valid_c[i] = 1'b1;
      end
    end
  end

  // Accept pulse only from IDLE, and never while reset is held.
  assign bus.req_ready  = (state == IDLE && !reset) ? pick_oh : '0;
  assign bus.core_start = (state == LAUNCH);
  assign bus.core_plain = core_plain_q;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed + randomized bench for aes_core_arbiter with a behavioural arbitration model.
// Timeout checks follow AES_ARB_TIMEOUT_EN when the bench is built with that macro.
module tb_aes_core_arbiter;
  import aes_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 128;
  localparam logic [W-1:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  arb_state_e dbg_state;

  always #5 clk = ~clk;

  aes_core_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  aes_core_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int           n_assert = 0;
  int           n_fail   = 0;
  logic [N-1:0] pend;
  logic [W-1:0] mdata [N];
  int           mptr;
  logic [W-1:0] last_rsp;
  logic [W-1:0] exp_q [$];
  int           grant_log [$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the AES core: any fixed bijection is enough to tag each job.
  function automatic logic [W-1:0] cipher_of(input logic [W-1:0] x);
    return {x[63:0], x[127:64]} ^ KEY;
  endfunction

  // Winner = first pending requester counting up from the pointer, modulo N.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    bus.req_valid = pend;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = mdata[i];
  endtask

  task automatic add_req(input int i);
    pend[i]  = 1'b1;
    mdata[i] = rand_block();
  endtask

  // One complete job: accept, launch, wait lat cycles for done (0 = never), respond after dly.
  task automatic run_job(input int lat, input int dly, input bit spur, input bit refill);
    int           win;
    int           obs_idx;
    int           wait_len;
    bit           exp_to;
    logic [N-1:0] oh;
    logic [W-1:0] exp_rsp;

    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.core_done = 1'b0;
    drive_reqs();
    #1;
    win = model_pick();
    oh  = '0;
    if (win >= 0) oh[win] = 1'b1;
    check("accept_req_ready", bus.req_ready, oh);
    check("accept_state", dbg_state, IDLE);
    check("accept_busy", busy, 1'b0);
    obs_idx = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) obs_idx = i;
    grant_log.push_back(obs_idx);

    exp_to = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    if (lat == 0 || lat > TIMEOUT_CYCLES) exp_to = 1'b1;
`endif
    wait_len = exp_to ? TIMEOUT_CYCLES : lat;
    exp_q.push_back(exp_to ? '0 : cipher_of(mdata[win]));

    @(negedge clk);
    #1;
    check("launch_core_start", bus.core_start, 1'b1);
    check("launch_core_plain", bus.core_plain, mdata[win]);
    check("launch_req_ready", bus.req_ready, '0);
    check("launch_state", dbg_state, LAUNCH);

    for (int k = 1; k <= wait_len; k++) begin
      @(negedge clk);
      bus.core_done   = (k == lat);
      bus.core_cipher = (k == lat) ? cipher_of(bus.core_plain) : rand_block();
      #1;
      check("wait_core_start", bus.core_start, 1'b0);
      check("wait_rsp_valid", bus.rsp_valid, '0);
      check("wait_req_ready", bus.req_ready, '0);
      check("wait_busy", busy, 1'b1);
      check("wait_error", bus.rsp_error, 1'b0);
    end

    exp_rsp = exp_q.pop_front();
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      bus.core_done   = spur && (i == 0);
      bus.core_cipher = ~exp_rsp;
      bus.rsp_ready   = (i == dly);
      #1;
      check("rsp_valid", bus.rsp_valid, oh);
      check("rsp_data", bus.rsp_data, exp_rsp);
      check("rsp_error", bus.rsp_error, exp_to);
      check("rsp_req_ready", bus.req_ready, '0);
      check("rsp_state", dbg_state, RESPOND);
    end

    mptr = (win + 1) % N;
    if (refill) mdata[win] = rand_block();
    else pend[win] = 1'b0;
    last_rsp = exp_rsp;

    @(posedge clk);
    #1;
    drive_reqs();
    bus.rsp_ready = 1'b0;
    bus.core_done = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, '0);
    check("post_rsp_error", bus.rsp_error, 1'b0);
    check("post_state", dbg_state, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pend  = '0;
    mptr  = 0;
    last_rsp = '0;
    for (int i = 0; i < N; i++) mdata[i] = '0;
    reset           = 1'b1;
    bus.req_valid   = '1;
    bus.req_data    = '0;
    bus.core_done   = 1'b1;
    bus.core_cipher = '1;
    bus.rsp_ready   = 1'b0;

    // Reset state with every input shouting.
    @(negedge clk);
    #1;
    check("reset_req_ready", bus.req_ready, '0);
    check("reset_core_start", bus.core_start, 1'b0);
    check("reset_core_plain", bus.core_plain, '0);
    check("reset_rsp_valid", bus.rsp_valid, '0);
    check("reset_rsp_data", bus.rsp_data, '0);
    check("reset_rsp_error", bus.rsp_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_state", dbg_state, IDLE);
    @(negedge clk);
    bus.req_valid = '0;
    bus.core_done = 1'b0;
    reset         = 1'b0;

    // Single request with a fixed plaintext, core done 4 cycles after start.
    pend     = 4'b0001;
    mdata[0] = 128'h00112233445566778899aabbccddeeff;
    run_job(4, 0, 1'b0, 1'b0);

    // Reset while WAITing, then a late core_done must be ignored.
    add_req(2);
    @(negedge clk);
    drive_reqs();
    #1;
    check("rw_req_ready", bus.req_ready, 4'b0100);
    @(negedge clk);
    #1;
    check("rw_launch", dbg_state, LAUNCH);
    @(negedge clk);
    #1;
    check("rw_wait", dbg_state, WAIT);
    @(negedge clk);
    reset = 1'b1;
    pend  = '0;
    drive_reqs();
    #1;
    check("rw_state", dbg_state, IDLE);
    check("rw_core_plain", bus.core_plain, '0);
    check("rw_rsp_valid", bus.rsp_valid, '0);
    check("rw_rsp_data", bus.rsp_data, '0);
    check("rw_busy", busy, 1'b0);
    check("rw_core_start", bus.core_start, 1'b0);
    mptr     = 0;
    last_rsp = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.core_done   = (k == 0);
      bus.core_cipher = rand_block();
      #1;
      check("late_done_state", dbg_state, IDLE);
      check("late_done_rsp_valid", bus.rsp_valid, '0);
      check("late_done_rsp_data", bus.rsp_data, '0);
    end
    bus.core_done = 1'b0;

    // Fairness: all requesters stay valid for 8 jobs.
    grant_log.delete();
    for (int i = 0; i < N; i++) add_req(i);
    for (int j = 0; j < 8; j++) run_job($urandom_range(1, 6), $urandom_range(0, 2), 1'b0, 1'b1);
    for (int j = 0; j < 8; j++) check("grant_order", grant_log[j], j % N);

    // Response held off for 5 cycles with others still requesting.
    run_job(3, 5, 1'b0, 1'b1);

    // Spurious core_done while idle and while responding.
    pend = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_reqs();
      bus.core_done   = 1'b1;
      bus.core_cipher = rand_block();
      #1;
      check("spur_idle_state", dbg_state, IDLE);
      check("spur_idle_rsp_valid", bus.rsp_valid, '0);
      check("spur_idle_rsp_data", bus.rsp_data, last_rsp);
      check("spur_idle_core_start", bus.core_start, 1'b0);
    end
    bus.core_done = 1'b0;
    add_req(1);
    run_job(2, 2, 1'b1, 1'b0);

    // Randomized traffic: losers keep requesting, new requests arrive at random.
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) add_req(i);
      if (pend == '0) add_req($urandom_range(0, N - 1));
      run_job($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1);
    end

    // Core that never answers, then one answering exactly at the timeout cycle.
    pend = '0;
    add_req(3);
`ifdef AES_ARB_TIMEOUT_EN
    run_job(0, 1, 1'b0, 1'b1);
    run_job(TIMEOUT_CYCLES, 1, 1'b0, 1'b0);
`else
    run_job(100, 1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one AES encryption core.
REQ-002 Parameter DATA_W, default 128, block width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester job request.
REQ-006 req_data  input  NUM_REQ*DATA_W  per-requester plaintext; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester.
REQ-008 core_start  output  1  one-cycle start pulse to the AES core.
REQ-009 core_plain  output  DATA_W  latched plaintext driven to the core.
REQ-010 core_done  input  1  core completion pulse.
REQ-011 core_cipher  input  DATA_W  core ciphertext, valid while core_done=1.
REQ-012 rsp_valid  output  NUM_REQ  one-hot response valid to the granted requester.
REQ-013 rsp_data  output  DATA_W  response ciphertext.
REQ-014 rsp_ready  input  1  response accept, applies to the requester whose rsp_valid bit is set.
REQ-015 rsp_error  output  1  timeout flag; constant 0 when the timeout feature is compiled out.
REQ-016 busy  output  1  high in every state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT, RESPOND.
REQ-018 IDLE, any req_valid=1: select the winner round-robin from rr_ptr upward with wrap; pulse req_ready[winner] the same cycle; latch the winner's req_data into core_plain and the winner's index into grant; go to LAUNCH.
REQ-019 IDLE, no req_valid: stay in IDLE with req_ready=0.
REQ-020 LAUNCH: core_start=1 for exactly one cycle; go to WAIT.
REQ-021 WAIT: on core_done=1, capture core_cipher into rsp_data and go to RESPOND; otherwise stay in WAIT.
REQ-022 core_done SHALL be ignored in IDLE, LAUNCH and RESPOND.
REQ-023 RESPOND: hold rsp_valid[grant]=1 and rsp_data stable until rsp_ready=1.
REQ-024 On the RESPOND handshake cycle: set rr_ptr=(grant+1) mod NUM_REQ; go to IDLE. A new grant is possible on the following cycle.
REQ-025 Minimum latency from the accept cycle to rsp_valid SHALL be core latency + 2 cycles.
REQ-026 Requesters that lose arbitration SHALL keep req_valid asserted; no request is dropped.
REQ-027 Fairness: with all requesters permanently valid, grants SHALL rotate 0,1,2,3,0,...
REQ-028 req_ready SHALL be asserted only in IDLE, so at most one job is outstanding.
REQ-029 rr_ptr SHALL be $clog2(NUM_REQ) bits wide and wrap modulo NUM_REQ.

Reset
REQ-030 Reset SHALL drive: state=IDLE, rr_ptr=0, grant=0, core_plain=0, rsp_data=0, timeout counter=0.
REQ-031 Reset SHALL drive all outputs to 0.
REQ-032 Reset asserted mid-job SHALL abandon the job with no response; any later core_done SHALL be ignored while in IDLE.

Configuration
REQ-033 Macro AES_ARB_TIMEOUT_EN defined:
- A 6-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When the counter reaches TIMEOUT_CYCLES (63) with no core_done, go to RESPOND with rsp_error=1 and rsp_data=0.
- rsp_error SHALL clear on the handshake.
- core_done on the same cycle as the timeout SHALL take priority: normal response, rsp_error=0.
REQ-034 Macro undefined: no counter; WAIT waits indefinitely; rsp_error tied to 0.

Structure
REQ-035 Package aes_arb_pkg SHALL hold arb_state_e (IDLE, LAUNCH, WAIT, RESPOND), NUM_REQ_DEF, DATA_W_DEF and TIMEOUT_CYCLES.
REQ-036 Sub-module rr_picker SHALL be combinational: inputs req vector and rr_ptr; outputs one-hot grant and any_req.

Verification
REQ-037 Single request: req_valid=0001, data=0x00112233445566778899aabbccddeeff, core done 4 cycles after start -> req_ready=0001 once, core_start 1 cycle later, rsp_valid=0001 with the core_cipher value.
REQ-038 All four requesters held valid for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-039 rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable throughout, no new req_ready.
REQ-040 Spurious core_done in IDLE and in RESPOND -> no state change, rsp_data unchanged.
REQ-041 Reset pulse in WAIT, then a late core_done -> all outputs 0, FSM in IDLE, no rsp_valid.
REQ-042 With AES_ARB_TIMEOUT_EN and core_done never asserted -> rsp_valid with rsp_error=1 and rsp_data=0 after 63 WAIT cycles; a second run with core_done on cycle 63 -> rsp_error=0.
